// File: rtl/execution_unit_muldiv.sv
// BRISC-V execute stage: single-cycle base ALU plus an iterative RV32M
// multiply/divide unit (one bit per cycle) behind a valid/ready handshake.
module execution_unit_muldiv #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              ALU_Operation,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  input  logic [ADDRESS_BITS-1:0] PC,
  input  logic [1:0]              ALU_ASrc,
  input  logic                    ALU_BSrc,
  input  logic                    branch_op,
  input  logic [DATA_WIDTH-1:0]   regRead_1,
  input  logic [DATA_WIDTH-1:0]   regRead_2,
  input  logic [DATA_WIDTH-1:0]   extend,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   ALU_result,
  output logic                    zero,
  output logic                    branch,
  output logic [ADDRESS_BITS-1:0] JALR_target,
  output logic                    stall,
  input  logic                    report
);

  localparam int W   = DATA_WIDTH;
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int CW  = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            divz_q, divz_d;
  logic [31:0]     cycles_q;

  // ---------------- base ALU ----------------
  logic [5:0]     alu_ctrl;
  logic [W-1:0]   op_a, op_b, base_res;
  logic [SHW-1:0] shamt;
  logic           br_cond, base_branch;

  always_comb begin
    alu_ctrl = 6'b000000;
    if (ALU_Operation == 3'b011)
      alu_ctrl = 6'b011111;
    else if (ALU_Operation == 3'b010)
      alu_ctrl = {3'b010, funct3};
    else if (ALU_Operation == 3'b000)
      alu_ctrl = (funct7 == 7'b0100000) ? {3'b001, funct3} : {3'b000, funct3};
    else if (ALU_Operation == 3'b001)
      alu_ctrl = (funct3 == 3'b101 && funct7 == 7'b0100000) ? 6'b001101 : {3'b000, funct3};
  end

  always_comb begin
    unique case (ALU_ASrc)
      2'b01:   op_a = W'(PC);
      2'b10:   op_a = W'(PC) + W'(4);
      default: op_a = regRead_1;
    endcase
    op_b  = ALU_BSrc ? extend : regRead_2;
    shamt = op_b[SHW-1:0];
  end

  always_comb begin
    unique case (funct3)
      3'b000:  br_cond = (op_a == op_b);
      3'b001:  br_cond = (op_a != op_b);
      3'b100:  br_cond = ($signed(op_a) <  $signed(op_b));
      3'b101:  br_cond = ($signed(op_a) >= $signed(op_b));
      3'b110:  br_cond = (op_a <  op_b);
      3'b111:  br_cond = (op_a >= op_b);
      default: br_cond = 1'b0;
    endcase
    base_branch = (alu_ctrl[5:3] == 3'b010) & br_cond & branch_op;
  end

  always_comb begin
    base_res = op_a + op_b;
    case (alu_ctrl)
      6'b001000: base_res = op_a - op_b;
      6'b000001: base_res = op_a << shamt;
      6'b000010: base_res = {{(W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      6'b000011: base_res = {{(W-1){1'b0}}, op_a < op_b};
      6'b000100: base_res = op_a ^ op_b;
      6'b000101: base_res = op_a >> shamt;
      6'b001101: base_res = $signed(op_a) >>> shamt;
      6'b000110: base_res = op_a | op_b;
      6'b000111: base_res = op_a & op_b;
      6'b010000, 6'b010001, 6'b010100,
      6'b010101, 6'b010110, 6'b010111:
                 base_res = {{(W-1){1'b0}}, br_cond};
      6'b011111: base_res = op_a;
      default:   base_res = op_a + op_b;
    endcase
  end

  assign JALR_target = ADDRESS_BITS'(regRead_1 + extend) & {{(ADDRESS_BITS-1){1'b1}}, 1'b0};

  // ---------------- M extension datapath ----------------
  logic         mop, accept;
  logic         a_sgn, b_sgn, a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;

  assign mop    = in_valid & (ALU_Operation == 3'b000) & (funct7 == 7'b0000001);
  assign accept = (state_q == IDLE) & mop;

  always_comb begin
    a_sgn = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_sgn = funct3[2] ? ~funct3[0] : ~funct3[1];
    a_neg = a_sgn & regRead_1[W-1];
    b_neg = b_sgn & regRead_2[W-1];
    a_mag = a_neg ? -regRead_1 : regRead_1;
    b_mag = b_neg ? -regRead_2 : regRead_2;
  end

  // MUL keeps the multiplicand in opnd_q and shifts the multiplier out of
  // acc_q's low half; DIV keeps the divisor in opnd_q and shifts the dividend
  // out of the low half while quotient bits shift in behind it.
  logic [W:0]     add_sum, r_sh, diff;
  logic [2*W-1:0] mul_next, div_next;

  always_comb begin
    add_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {add_sum, acc_q[W-1:1]};
    r_sh     = acc_q[2*W-1:W-1];
    diff     = r_sh - {1'b0, opnd_q};
    div_next = diff[W] ? {r_sh[W-1:0], acc_q[W-2:0], 1'b0}
                       : {diff[W-1:0], acc_q[W-2:0], 1'b1};
  end

  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem, m_result;

  always_comb begin
    prod = neg_res_q ? -acc_q : acc_q;
    quo  = acc_q[W-1:0];
    rem  = acc_q[2*W-1:W];
    unique case (f3_q)
      3'b000:         m_result = prod[W-1:0];
      3'b001, 3'b010,
      3'b011:         m_result = prod[2*W-1:W];
      3'b100, 3'b101: m_result = divz_q ? '1 : (neg_res_q ? -quo : quo);
      default:        m_result = neg_rem_q ? -rem : rem;
    endcase
  end

  // ---------------- control FSM ----------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;
    in_ready  = 1'b0;
    stall     = 1'b0;
    out_valid = 1'b0;
    branch    = 1'b0;
    ALU_result = base_res;

    unique case (state_q)
      IDLE: begin
        in_ready  = 1'b1;
        stall     = mop;
        out_valid = in_valid & ~mop;
        branch    = base_branch;
        if (accept) begin
          f3_d      = funct3;
          cnt_d     = '0;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          divz_d    = (regRead_2 == '0);
          opnd_d    = funct3[2] ? b_mag : a_mag;
          acc_d     = {{W{1'b0}}, (funct3[2] ? a_mag : b_mag)};
          state_d   = funct3[2] ? DIV : MUL;
        end
      end
      MUL, DIV: begin
        stall = 1'b1;
        acc_d = (state_q == MUL) ? mul_next : div_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid  = 1'b1;
        ALU_result = m_result;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    zero = (ALU_result == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      f3_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
      cycles_q  <= cycles_q + 32'd1;
    end
  end

  // Trace hooks kept for the simulation-side reporter; no logic depends on them.
  logic unused_report;
  assign unused_report = ^{report, cycles_q, (CORE != 0)};

endmodule

// File: tb/tb_execution_unit_muldiv.sv
// Directed bench for execution_unit_muldiv: base ALU vectors, iterative
// M-op latency/result checks, and reset during an in-flight divide.
module tb_execution_unit_muldiv;

  localparam int W  = 32;
  localparam int AB = 20;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    ALU_Operation;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [AB-1:0] PC;
  logic [1:0]    ALU_ASrc;
  logic          ALU_BSrc;
  logic          branch_op;
  logic [W-1:0]  regRead_1, regRead_2, extend;
  logic          out_valid;
  logic [W-1:0]  ALU_result;
  logic          zero;
  logic          branch;
  logic [AB-1:0] JALR_target;
  logic          stall;
  logic          report;

  always #5 clock = ~clock;

  execution_unit_muldiv #(.CORE(0), .DATA_WIDTH(W), .ADDRESS_BITS(AB)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_Operation(ALU_Operation), .funct3(funct3), .funct7(funct7), .PC(PC),
    .ALU_ASrc(ALU_ASrc), .ALU_BSrc(ALU_BSrc), .branch_op(branch_op),
    .regRead_1(regRead_1), .regRead_2(regRead_2), .extend(extend),
    .out_valid(out_valid), .ALU_result(ALU_result), .zero(zero), .branch(branch),
    .JALR_target(JALR_target), .stall(stall), .report(report)
  );

  typedef struct packed {
    logic          mop;
    logic [2:0]    op;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [1:0]    asrc;
    logic          bsrc;
    logic          brop;
    logic [W-1:0]  rs1;
    logic [W-1:0]  rs2;
    logic [W-1:0]  ext;
    logic [AB-1:0] pc;
    logic          chk_res;
    logic [W-1:0]  exp_res;
    logic          exp_br;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t vb(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [1:0] asrc, input logic bsrc, input logic brop,
                              input logic [W-1:0] rs1, input logic [W-1:0] rs2,
                              input logic [W-1:0] ext, input logic [AB-1:0] pc,
                              input logic chk, input logic [W-1:0] exp, input logic br);
    vec_t v;
    v.mop = 1'b0; v.op = op; v.f3 = f3; v.f7 = f7; v.asrc = asrc; v.bsrc = bsrc;
    v.brop = brop; v.rs1 = rs1; v.rs2 = rs2; v.ext = ext; v.pc = pc;
    v.chk_res = chk; v.exp_res = exp; v.exp_br = br;
    return v;
  endfunction

  function automatic vec_t vm(input logic [2:0] f3, input logic [W-1:0] rs1,
                              input logic [W-1:0] rs2, input logic [W-1:0] exp);
    vec_t v;
    v = vb(3'b000, f3, 7'b0000001, 2'b00, 1'b0, 1'b0, rs1, rs2, '0, '0, 1'b1, exp, 1'b0);
    v.mop = 1'b1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ALU_Operation = v.op;  funct3 = v.f3;  funct7 = v.f7;
    ALU_ASrc = v.asrc;     ALU_BSrc = v.bsrc; branch_op = v.brop;
    regRead_1 = v.rs1;     regRead_2 = v.rs2; extend = v.ext; PC = v.pc;
    in_valid = 1'b1;
  endtask

  task automatic apply_base(input vec_t v, input int idx);
    logic [W-1:0]  s;
    logic [AB-1:0] exp_j;
    @(negedge clock);
    drive(v);
    #2;
    s = v.rs1 + v.ext;
    exp_j = s[AB-1:0];
    exp_j[0] = 1'b0;
    check($sformatf("v%0d_out_valid", idx), out_valid, 1'b1);
    check($sformatf("v%0d_branch", idx), branch, v.exp_br);
    check($sformatf("v%0d_jalr", idx), JALR_target, exp_j);
    if (v.chk_res) begin
      check($sformatf("v%0d_result", idx), ALU_result, v.exp_res);
      check($sformatf("v%0d_zero", idx), zero, v.exp_res == '0);
    end
    in_valid = 1'b0;
  endtask

  // Holds a base ADD 1+2 on the inputs while the M-op is in flight: it must be
  // ignored until the unit is back in IDLE, where it completes as a normal op.
  task automatic run_mop(input vec_t v, input int idx, input vec_t filler);
    int           first_bad;
    logic [W-1:0] res;
    logic         zr;
    first_bad = 0; res = '0; zr = 1'b0;
    @(negedge clock);
    drive(v);
    #2;
    check($sformatf("v%0d_accept", idx), {stall, in_ready, out_valid}, 3'b110);
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clock);
      if (k == 1) drive(filler);
      #2;
      if (k <= W) begin
        if (!(stall && !in_ready && !out_valid) && first_bad == 0) first_bad = k;
      end else if (k == W + 1) begin
        res = ALU_result;
        zr  = zero;
        if (!(!stall && !in_ready && out_valid && !branch) && first_bad == 0) first_bad = k;
      end else begin
        if (!(!stall && in_ready && out_valid && ALU_result == 32'd3) && first_bad == 0) first_bad = k;
      end
    end
    in_valid = 1'b0;
    check($sformatf("v%0d_timing_first_bad_cycle", idx), first_bad, 0);
    check($sformatf("v%0d_result", idx), res, v.exp_res);
    check($sformatf("v%0d_zero", idx), zr, v.exp_res == '0);
  endtask

  vec_t vecs[$];
  vec_t add12, add_filler;

  initial begin
    reset = 1'b1; report = 1'b0; in_valid = 1'b0;
    ALU_Operation = '0; funct3 = '0; funct7 = '0; PC = '0; ALU_ASrc = '0;
    ALU_BSrc = 1'b0; branch_op = 1'b0; regRead_1 = '0; regRead_2 = '0; extend = '0;

    add12      = vb(3'b000, 3'b000, 7'h00, 2'b00, 1'b0, 1'b0, 32'd5, 32'd7, '0, '0, 1'b1, 32'd12, 1'b0);
    add_filler = vb(3'b000, 3'b000, 7'h00, 2'b00, 1'b0, 1'b0, 32'd1, 32'd2, '0, '0, 1'b1, 32'd3, 1'b0);

    vecs.push_back(add12);
    vecs.push_back(vb(3'b000, 3'b000, 7'h20, 2'b00, 1'b0, 1'b0, 32'd5, 32'd7, '0, '0, 1'b1, 32'hFFFF_FFFE, 1'b0));
    vecs.push_back(vb(3'b000, 3'b101, 7'h20, 2'b00, 1'b0, 1'b0, 32'h8000_0000, 32'd4, '0, '0, 1'b1, 32'hF800_0000, 1'b0));
    vecs.push_back(vb(3'b001, 3'b101, 7'h20, 2'b00, 1'b1, 1'b0, 32'h8000_0000, '0, 32'h404, '0, 1'b1, 32'hF800_0000, 1'b0));
    vecs.push_back(vb(3'b001, 3'b101, 7'h00, 2'b00, 1'b1, 1'b0, 32'h8000_0000, '0, 32'd4, '0, 1'b1, 32'h0800_0000, 1'b0));
    vecs.push_back(vb(3'b000, 3'b010, 7'h00, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, '0, '0, 1'b1, 32'd1, 1'b0));
    vecs.push_back(vb(3'b000, 3'b011, 7'h00, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, '0, '0, 1'b1, 32'd0, 1'b0));
    vecs.push_back(vb(3'b001, 3'b000, 7'h7F, 2'b00, 1'b1, 1'b0, 32'd10, '0, 32'hFFFF_FFFF, '0, 1'b1, 32'd9, 1'b0));
    vecs.push_back(vb(3'b000, 3'b100, 7'h00, 2'b00, 1'b0, 1'b0, 32'hF0F0, 32'hFF00, '0, '0, 1'b1, 32'h0FF0, 1'b0));
    vecs.push_back(vb(3'b010, 3'b000, 7'h00, 2'b00, 1'b0, 1'b1, 32'h55, 32'h55, '0, '0, 1'b0, '0, 1'b1));
    vecs.push_back(vb(3'b010, 3'b001, 7'h00, 2'b00, 1'b0, 1'b1, 32'h55, 32'h55, '0, '0, 1'b0, '0, 1'b0));
    vecs.push_back(vb(3'b010, 3'b100, 7'h00, 2'b00, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, '0, '0, 1'b0, '0, 1'b1));
    vecs.push_back(vb(3'b010, 3'b000, 7'h00, 2'b00, 1'b0, 1'b0, 32'h55, 32'h55, '0, '0, 1'b0, '0, 1'b0));
    vecs.push_back(vb(3'b011, 3'b000, 7'h00, 2'b10, 1'b1, 1'b0, 32'h101, '0, 32'd4, 20'h100, 1'b1, 32'h104, 1'b0));
    vecs.push_back(vb(3'b100, 3'b000, 7'h00, 2'b01, 1'b1, 1'b0, '0, '0, 32'h1000, 20'h200, 1'b1, 32'h1200, 1'b0));
    vecs.push_back(vb(3'b001, 3'b000, 7'h01, 2'b00, 1'b1, 1'b0, 32'd3, '0, 32'd4, '0, 1'b1, 32'd7, 1'b0));
    vecs.push_back(vm(3'b000, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD));
    vecs.push_back(vm(3'b001, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF));
    vecs.push_back(vm(3'b011, 32'hFFFF_FFFF, 32'd3, 32'h0000_0002));
    vecs.push_back(vm(3'b010, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF));
    vecs.push_back(vm(3'b000, 32'd6, 32'd7, 32'd42));
    vecs.push_back(vm(3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF));
    vecs.push_back(vm(3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000));
    vecs.push_back(vm(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE));
    vecs.push_back(vm(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD));
    vecs.push_back(vm(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF));
    vecs.push_back(vm(3'b101, 32'd7, 32'd0, 32'hFFFF_FFFF));
    vecs.push_back(vm(3'b111, 32'd7, 32'd0, 32'd7));
    vecs.push_back(vm(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000));
    vecs.push_back(vm(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0));
    vecs.push_back(vm(3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF));
    vecs.push_back(vm(3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9));
    vecs.push_back(vm(3'b101, 32'd100, 32'd7, 32'd14));
    vecs.push_back(vm(3'b111, 32'd100, 32'd7, 32'd2));
    vecs.push_back(vm(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD));
    vecs.push_back(vm(3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1));

    // Reset state while reset is held, then after release.
    repeat (2) @(negedge clock);
    #2;
    check("reset_held_ready_stall_valid", {in_ready, stall, out_valid}, 3'b100);
    reset = 1'b0;
    @(negedge clock);
    #2;
    check("post_reset_ready_stall_valid", {in_ready, stall, out_valid}, 3'b100);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].mop) run_mop(vecs[i], i, add_filler);
      else             apply_base(vecs[i], i);
    end

    // Reset asserted during cycle 10 of a DIV aborts it without any result.
    begin
      int bad;
      bad = 0;
      @(negedge clock);
      drive(vm(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD));
      for (int k = 1; k <= 10; k++) begin
        @(negedge clock);
        in_valid = 1'b0;
      end
      #1 reset = 1'b1;
      #1;
      check("div_abort_reset_ready_stall_valid", {in_ready, stall, out_valid}, 3'b100);
      @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k < W + 8; k++) begin
        @(negedge clock);
        #2;
        if (out_valid || stall || !in_ready) bad++;
      end
      check("div_abort_no_late_result_cycles", bad, 0);
      apply_base(add12, 99);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/execution_unit_muldiv.md
# execution_unit_muldiv

Parametrised successor to the single-cycle execution unit: adds the RV32M multiply/divide group, executed iteratively over DATA_WIDTH cycles, alongside the unchanged single-cycle base ALU path. It sits between decode and memory in the BRISC-V single-cycle core. A valid/ready handshake and a stall output let the fetch/decode stages freeze while a long operation is in flight.

## Interface
- CORE, 0, core index printed in report output
- DATA_WIDTH, 32, operand/result width; must be even and ≥ 8
- ADDRESS_BITS, 20, PC and JALR target width
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- in_valid  in  1  instruction fields and operands present this cycle
- in_ready  out  1  unit can accept; high only in IDLE
- ALU_Operation  in  3  decode class (000 R, 001 I, 010 branch, 011 JAL/JALR, others add)
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7
- PC  in  ADDRESS_BITS  current PC
- ALU_ASrc  in  2  operand A select: 00 regRead_1, 01 PC, 10 PC+4
- ALU_BSrc  in  1  operand B select: 0 regRead_2, 1 extend
- branch_op  in  1  instruction is a conditional branch
- regRead_1, regRead_2, extend  in  DATA_WIDTH each  register reads, sign-extended immediate
- out_valid  out  1  ALU_result/zero/branch valid this cycle
- ALU_result  out  DATA_WIDTH  result
- zero  out  1  ALU_result == 0
- branch  out  1  branch taken (base ALU branch result AND branch_op)
- JALR_target  out  ADDRESS_BITS  (regRead_1 + extend) with bit 0 cleared, combinational
- stall  out  1  hold upstream stages
- report  in  1  print per-cycle state via $display

## Operation
- M-op: in_valid & ALU_Operation==000 & funct7==0000001. All other combinations are base ops, decoded to ALU control exactly as the previous generation (JAL/JALR pass, branches {010,funct3}, SUB/SRA via funct7==0100000, SRAI via I-type funct7, default add).
- Base op in IDLE: combinational; out_valid = in_valid, result same cycle, no state change.
- States: IDLE, MUL, DIV, DONE. IDLE→MUL on accepted funct3 000–011; IDLE→DIV on 100–111; MUL/DIV→DONE when step counter reaches DATA_WIDTH-1; DONE→IDLE unconditionally.
- On acceptance, latch funct3, operand magnitudes and result-sign flags; upstream need not hold inputs afterwards.
- MUL: unsigned shift-add, one multiplier bit per cycle, 2·DATA_WIDTH accumulator. Signedness: MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned. MUL returns low half, MULH* high half of the sign-corrected product.
- DIV: restoring, one quotient bit per cycle on magnitudes; quotient takes sign rs1^rs2, remainder takes sign of rs1 (DIV/REM); DIVU/REMU unsigned.
- Special cases, applied in DONE: divisor 0 → quotient all-ones, remainder = dividend; signed most-negative ÷ −1 → quotient = dividend, remainder 0.
- DONE: out_valid=1, ALU_result = registered result, zero from it, branch=0.
- in_ready=1 only in IDLE; stall = (IDLE & M-op) | MUL | DIV.
- Base-op in_valid presented while busy is ignored; upstream is stalled.

## Timing
- Reset (any time, incl. mid-operation): state IDLE, counter 0, latched operands/result 0; operation aborted, no out_valid for it. After reset, in_ready=1, stall=0, out_valid follows base-op in_valid.
- M-op latency: accepted in cycle 0; MUL/DIV in cycles 1..DATA_WIDTH; DONE (out_valid=1) in cycle DATA_WIDTH+1; IDLE and in_ready=1 in cycle DATA_WIDTH+2. For DATA_WIDTH=32: result cycle 33.
- Fixed latency for every M-op, including special cases.
- Back-to-back M-ops: the second is accepted no earlier than cycle DATA_WIDTH+2.
- report counter: cycles resets to 0, increments every clock.

## Test plan
- Reset release, ADD 5+7 (R, funct7 0) -> out_valid same cycle, ALU_result=12, in_ready=1, stall=0.
- MUL 0xFFFFFFFF×3 -> stall cycles 0–32, out_valid only cycle 33, result 0xFFFFFFFD; MULH -> 0xFFFFFFFF; MULHU -> 0x00000002.
- DIV −7/2 -> quotient 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7.
- DIV 0x80000000/−1 -> 0x80000000; REM same operands -> 0, zero=1.
- Reset asserted in cycle 10 of a DIV -> IDLE immediately, no out_valid; next ADD returns normally.
- BEQ equal operands, branch_op=1 -> branch=1 same cycle; JALR regRead_1=0x101, extend=4 -> JALR_target=0x104.
